// File: rtl/lfsr_pkg.sv
// Shared constants and types for the programmable-tap Fibonacci LFSR.
package lfsr_pkg;

    localparam int unsigned LFSR_WIDTH_DEFAULT = 5;

    // x^5 + x^2 + 1, maximal length (period 31) for a 5-bit register
    localparam logic [4:0] TAPS_W5_MAX = 5'b10100;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_STEP = 2'd1,
        OP_LOAD = 2'd2
    } lfsr_op_e;

    // rst and reinit both reload the seed; either outranks a step
    function automatic lfsr_op_e lfsr_select_op(input logic rst, input logic reinit,
                                                input logic advance);
        lfsr_op_e op;
        op = OP_HOLD;
        if (rst || reinit) begin
            op = OP_LOAD;
        end else if (advance) begin
            op = OP_STEP;
        end
        return op;
    endfunction

endpackage

// File: rtl/lfsr_feedback.sv
// Feedback bit: XOR parity of the register bits selected by the tap mask.
module lfsr_feedback
    import lfsr_pkg::*;
#(
    parameter int unsigned WIDTH = LFSR_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] state,
    input  logic [WIDTH-1:0] taps,
    output logic             fb_c
);

    always_comb begin
        fb_c = ^(state & taps);
    end

endmodule

// File: rtl/lfsr.sv
// Fibonacci LFSR with run-time tap mask and seed; shifts left, parity enters at bit 0.
module lfsr
    import lfsr_pkg::*;
#(
    parameter int unsigned WIDTH = LFSR_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reinit,
    input  logic             advance,
    input  logic [WIDTH-1:0] initial_state,
    input  logic [WIDTH-1:0] taps,
    output logic             out,
    output logic [WIDTH-1:0] out_state
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic             fb_c;
    lfsr_op_e         op_c;

    lfsr_feedback #(
        .WIDTH (WIDTH)
    ) u_feedback (
        .state (state_q),
        .taps  (taps),
        .fb_c  (fb_c)
    );

    // Seed is only consulted on a load, so an X seed never reaches the register otherwise
    always_comb begin
        state_d = state_q;
        op_c    = lfsr_select_op(rst, reinit, advance);
        case (op_c)
            OP_LOAD: state_d = initial_state;
            OP_STEP: state_d = {state_q[WIDTH-2:0], fb_c};
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= initial_state;
        end else begin
            state_q <= state_d;
        end
    end

    assign out       = state_q[0];
    assign out_state = state_q;

endmodule

// File: tb/tb_lfsr.sv
// Directed and randomized checks of lfsr against an arithmetic reference model.
module tb_lfsr;
    import lfsr_pkg::*;

    localparam int unsigned W = LFSR_WIDTH_DEFAULT;

    logic         clk     = 1'b0;
    logic         rst     = 1'b0;
    logic         reinit  = 1'b0;
    logic         advance = 1'b0;
    logic [W-1:0] init_s  = '0;
    logic [W-1:0] taps    = '0;
    logic         out;
    logic [W-1:0] out_state;

    int           tests = 0;
    int           fails = 0;
    logic [W-1:0] exp_s;
    logic [W-1:0] obs_q[$];

    lfsr #(
        .WIDTH (W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .reinit        (reinit),
        .advance       (advance),
        .initial_state (init_s),
        .taps          (taps),
        .out           (out),
        .out_state     (out_state)
    );

    always #5 clk = ~clk;

    // Next value: seed on load, else double the value mod 2^W and add tapped-ones parity
    function automatic logic [W-1:0] ref_next(input logic [W-1:0] s, input logic [W-1:0] t,
                                              input logic [W-1:0] seed, input logic r,
                                              input logic ri, input logic a);
        int          ones;
        int unsigned v;
        if (r || ri) return seed;
        if (!a) return s;
        ones = 0;
        for (int i = 0; i < W; i++) begin
            if (s[i] == 1'b1 && t[i] == 1'b1) ones++;
        end
        v = ((int'(s) * 2) % (1 << W)) + (ones % 2);
        return W'(v);
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick_check(input string tag);
        exp_s = ref_next(exp_s, taps, init_s, rst, reinit, advance);
        @(posedge clk);
        #1;
        check({tag, "_state"}, out_state, exp_s);
        check({tag, "_out"}, W'(out), W'(exp_s[0]));
    endtask

    initial begin
        int repeats;
        exp_s = 'x;
        @(negedge clk);

        // Reset loads the seed; seed is a don't-care afterwards
        rst = 1'b1; init_s = 5'b11010;
        tick_check("rst_load");
        check("rst_value", out_state, 5'b11010);
        rst = 1'b0; init_s = 'x;
        tick_check("idle_hold");
        check("idle_value", out_state, 5'b11010);

        // Maximal taps: 35 steps, period 31
        taps = TAPS_W5_MAX; advance = 1'b1;
        obs_q.delete();
        for (int k = 0; k < 35; k++) begin
            tick_check("max_step");
            obs_q.push_back(out_state);
        end
        for (int k = 31; k < 35; k++) begin
            check("period_31", obs_q[k], obs_q[k-31]);
        end
        repeats = 0;
        for (int k = 1; k < 31; k++) begin
            if (obs_q[k] == obs_q[0]) repeats++;
        end
        check("no_early_repeat", W'(repeats), '0);

        // reinit reloads and then holds
        advance = 1'b0; reinit = 1'b1; init_s = 5'b01011;
        tick_check("reinit_load");
        check("reinit_value", out_state, 5'b01011);
        reinit = 1'b0; init_s = 'x;
        tick_check("reinit_hold");
        check("reinit_hold_value", out_state, 5'b01011);

        // Priority among simultaneous controls
        reinit = 1'b1; advance = 1'b1; init_s = 5'b11100;
        tick_check("reinit_over_adv");
        check("reinit_over_adv_value", out_state, 5'b11100);
        rst = 1'b1; init_s = 5'b10001;
        tick_check("rst_over_all");
        check("rst_over_all_value", out_state, 5'b10001);

        // All-zero fixed point
        reinit = 1'b0; advance = 1'b0; init_s = 5'b00000;
        tick_check("zero_load");
        rst = 1'b0; advance = 1'b1; init_s = 'x;
        tick_check("zero_step1");
        tick_check("zero_step2");
        check("zero_stays", out_state, 5'b00000);

        // Tap change takes effect on the very next step
        rst = 1'b1; advance = 1'b0; init_s = 5'b10000;
        tick_check("taps_seed");
        rst = 1'b0; advance = 1'b1; init_s = 'x; taps = 5'b10100;
        tick_check("taps_a");
        check("taps_a_value", out_state, 5'b00001);
        taps = 5'b11000;
        tick_check("taps_b");
        check("taps_b_value", out_state, 5'b00010);

        // Randomized controls, taps and seeds
        for (int k = 0; k < 400; k++) begin
            rst     = ($urandom_range(0, 15) == 0);
            reinit  = ($urandom_range(0, 7) == 0);
            advance = ($urandom_range(0, 3) != 0);
            taps    = W'($urandom);
            if (rst || reinit) init_s = W'($urandom);
            else               init_s = 'x;
            tick_check("random");
        end

        rst = 1'b0; reinit = 1'b0; advance = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
